// File: rtl/clip_rr_pkg.sv
// ---------------------------------------------------------------------------
// clip_rr_pkg : shared constants and types for the clip_rr_sched block
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clip_rr_pkg;

  localparam int SR_CFG = 0;
  localparam int SR_CLR = 1;
  localparam int CNT_W  = 16;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

endpackage

`default_nettype wire

// File: rtl/clip_rr_sched_clip.sv
// ---------------------------------------------------------------------------
// clip : combinational two's-complement saturating narrower with bypass
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clip
  import clip_rr_pkg::*;
#(
  parameter int BITS_IN  = 24,
  parameter int BITS_OUT = 16
) (
  input  logic [BITS_IN-1:0]  in_data,
  input  logic                bypass,
  output logic [BITS_OUT-1:0] out_data,
  output logic                clipped
);

  // The dropped bits plus the new sign bit must all agree for a lossless fit.
  logic [BITS_IN-BITS_OUT:0] top;
  logic                      ovf;

  assign top = in_data[BITS_IN-1:BITS_OUT-1];
  assign ovf = !((&top) || !(|top));

  always_comb begin
    out_data = in_data[BITS_OUT-1:0];
    clipped  = 1'b0;
    if (!bypass && ovf) begin
      clipped  = 1'b1;
      out_data = in_data[BITS_IN-1] ? {1'b1, {(BITS_OUT-1){1'b0}}}
                                    : {1'b0, {(BITS_OUT-1){1'b1}}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/clip_rr_sched.sv
// ---------------------------------------------------------------------------
// clip_rr_sched : round-robin time-shared saturating clipper for NCH streams.
// Optional per-channel clip counters when CLIP_RR_STATS_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clip_rr_sched
  import clip_rr_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int BITS_IN  = 24,
  parameter int BITS_OUT = 16,
  parameter int SR_BASE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_stb,
  input  logic [7:0]             set_addr,
  input  logic [31:0]            set_data,
  input  logic [NCH*BITS_IN-1:0] in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  output logic [BITS_OUT-1:0]    out_data,
  output logic [2:0]             out_chan,
  output logic                   out_clip,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH-1:0]         clip_evt
`ifdef CLIP_RR_STATS_EN
  ,
  output logic [NCH*CNT_W-1:0]   stat_cnt
`endif
);

  localparam logic [7:0] ADDR_CFG = 8'(SR_BASE + SR_CFG);

  stage_state_t         state, state_nxt;
  logic [2:0]           ptr, ptr_nxt;
  logic [NCH-1:0]       cfg_mask;
  logic                 cfg_bypass;
  logic [NCH-1:0]       elig;
  logic [NCH-1:0]       grant;
  logic [2:0]           gidx;
  logic                 any_grant;
  logic [BITS_IN-1:0]   sel_data;
  logic                 load;
  logic [BITS_OUT-1:0]  clip_data;
  logic                 clipped;
  logic                 unused_set;

  assign elig       = in_valid & cfg_mask;
  assign out_valid  = (state == ST_FULL);
  assign unused_set = ^{set_data[31:8+NCH], set_data[7:1]};

  // Search starts at ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin : p_arb
    int idx;
    idx       = 0;
    grant     = '0;
    gidx      = '0;
    any_grant = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!any_grant && elig[idx]) begin
        any_grant  = 1'b1;
        gidx       = 3'(idx);
        grant[idx] = 1'b1;
        sel_data   = in_data[idx*BITS_IN +: BITS_IN];
      end
    end
  end

  clip #(
    .BITS_IN  (BITS_IN),
    .BITS_OUT (BITS_OUT)
  ) u_clip (
    .in_data  (sel_data),
    .bypass   (cfg_bypass),
    .out_data (clip_data),
    .clipped  (clipped)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    in_ready  = '0;
    load      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (any_grant) begin
          load      = 1'b1;
          in_ready  = grant;
          state_nxt = ST_FULL;
          ptr_nxt   = (gidx == 3'(NCH-1)) ? 3'd0 : gidx + 3'd1;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (any_grant) begin
            load     = 1'b1;
            in_ready = grant;
            ptr_nxt  = (gidx == 3'(NCH-1)) ? 3'd0 : gidx + 3'd1;
          end else begin
            state_nxt = ST_EMPTY;
          end
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_chan <= '0;
      out_clip <= 1'b0;
      clip_evt <= '0;
    end else begin
      clip_evt <= (load && clipped) ? grant : '0;
      if (load) begin
        out_data <= clip_data;
        out_chan <= gidx;
        out_clip <= clipped;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_mask   <= '1;
      cfg_bypass <= 1'b0;
    end else if (set_stb && set_addr == ADDR_CFG) begin
      cfg_mask   <= set_data[8 +: NCH];
      cfg_bypass <= set_data[0];
    end
  end

`ifdef CLIP_RR_STATS_EN
  localparam logic [7:0] ADDR_CLR = 8'(SR_BASE + SR_CLR);

  logic cnt_clr;
  assign cnt_clr = set_stb && (set_addr == ADDR_CLR);

  for (genvar c = 0; c < NCH; c++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    // Clear wins over a coincident clip event.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (cnt_clr) begin
        cnt <= '0;
      end else if (clip_evt[c] && cnt != {CNT_W{1'b1}}) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
    assign stat_cnt[c*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_clip_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_clip_rr_sched : randomized scoreboard bench for clip_rr_sched
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_clip_rr_sched;
  import clip_rr_pkg::*;

  localparam int NCH = 4;
  localparam int BI  = 24;
  localparam int BO  = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                set_stb;
  logic [7:0]          set_addr;
  logic [31:0]         set_data;
  logic [NCH*BI-1:0]   in_data;
  logic [NCH-1:0]      in_valid;
  logic [NCH-1:0]      in_ready;
  logic [BO-1:0]       out_data;
  logic [2:0]          out_chan;
  logic                out_clip;
  logic                out_valid;
  logic                out_ready;
  logic [NCH-1:0]      clip_evt;
`ifdef CLIP_RR_STATS_EN
  logic [NCH*CNT_W-1:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  clip_rr_sched #(.NCH(NCH), .BITS_IN(BI), .BITS_OUT(BO), .SR_BASE(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_clip  (out_clip),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clip_evt  (clip_evt)
`ifdef CLIP_RR_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  typedef struct {
    logic [15:0] d;
    int          ch;
    bit          clp;
    bit          fresh;
  } item_t;

  item_t       sb[$];
  item_t       pend;
  bit          have_pend;
  int          errors = 0;
  int          checks = 0;

  int          m_ptr;
  bit          m_full;
  logic [3:0]  m_mask;
  bit          m_byp;
  int          m_cnt[NCH];
  bit          m_wr;
  logic [7:0]  m_wa;
  logic [31:0] m_wd;
  int          gnt_ch;

  bit          src_v[NCH];
  logic [23:0] src_d[NCH];
  int          vprob[NCH];
  int          rprob;
  int          gen_mode;
  bit          in_rst;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: saturate by numeric range, not by bit pattern.
  function automatic item_t expect_item(logic [23:0] x, int ch, bit byp);
    item_t it;
    int    s;
    s        = $signed(x);
    it.ch    = ch;
    it.fresh = 1'b1;
    it.clp   = 1'b0;
    it.d     = x[15:0];
    if (!byp) begin
      if (s > 32767) begin
        it.d = 16'h7FFF; it.clp = 1'b1;
      end else if (s < -32768) begin
        it.d = 16'h8000; it.clp = 1'b1;
      end
    end
    return it;
  endfunction

  function automatic logic [23:0] gen_sample();
    logic signed [15:0] t;
    logic [21:0]        r;
    r = 22'($urandom);
    if (gen_mode == 1) return ($urandom_range(1) == 0) ? {2'b01, r} : {2'b10, r};
    case ($urandom_range(5))
      0: return 24'h007FFF;
      1: return 24'h008000;
      2: return 24'hFF7FFF;
      3: return 24'hFF8000;
      4: begin t = 16'($urandom); return {{8{t[15]}}, t}; end
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic set_src(input int c, input logic [23:0] d);
    src_v[c] = 1'b1;
    src_d[c] = d;
  endtask

  // One clock: commit last prediction at the edge, drive new inputs, predict at negedge.
  task automatic cycle(input bit do_wr, input logic [7:0] wa, input logic [31:0] wd);
    logic [3:0] elig;
    logic [3:0] exp_rdy;
    int         exp_g;
    int         idx;
    @(posedge clk);
    if (have_pend) begin
      sb.push_back(pend);
      have_pend = 1'b0;
    end
    if (gnt_ch >= 0) src_v[gnt_ch] = 1'b0;
    gnt_ch = -1;
    if (m_wr) begin
      if (m_wa == 8'd0) begin
        m_mask = m_wd[11:8];
        m_byp  = m_wd[0];
      end else if (m_wa == 8'd1) begin
`ifdef CLIP_RR_STATS_EN
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
`endif
      end
    end
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (!src_v[c] && $urandom_range(99) < vprob[c]) set_src(c, gen_sample());
      in_valid[c]           = src_v[c];
      in_data[c*BI +: BI]   = src_d[c];
    end
    out_ready = ($urandom_range(99) < rprob);
    set_stb   = do_wr;
    set_addr  = wa;
    set_data  = wd;
    m_wr = do_wr; m_wa = wa; m_wd = wd;
    @(negedge clk);
    elig  = '0;
    exp_g = -1;
    for (int c = 0; c < NCH; c++) elig[c] = src_v[c] & m_mask[c];
    if (!m_full || out_ready) begin
      for (int k = 0; k < NCH; k++) begin
        idx = (m_ptr + k) % NCH;
        if (exp_g < 0 && elig[idx]) exp_g = idx;
      end
    end
    exp_rdy = (exp_g >= 0) ? 4'(1 << exp_g) : 4'd0;
    check("in_ready", in_ready, exp_rdy);
    if (exp_g >= 0) begin
      pend      = expect_item(src_d[exp_g], exp_g, m_byp);
      have_pend = 1'b1;
      gnt_ch    = exp_g;
      m_ptr     = (exp_g + 1) % NCH;
      m_full    = 1'b1;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    have_pend = 1'b0;
    gnt_ch    = -1;
    m_ptr     = 0;
    m_full    = 1'b0;
    m_mask    = 4'hF;
    m_byp     = 1'b0;
    m_wr      = 1'b0;
    for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
  endtask

  // Monitor: compares whatever the output stage presents against the scoreboard head.
  initial begin : p_monitor
    item_t            it;
    logic [3:0]       exp_evt;
    logic [63:0]      exp_cnt;
    forever begin
      @(negedge clk);
      if (!in_rst) begin
        exp_evt = '0;
        check("out_valid", out_valid, sb.size() > 0);
        if (sb.size() > 0 && out_valid) begin
          it = sb[0];
          check("out_data", out_data, it.d);
          check("out_chan", out_chan, 3'(it.ch));
          check("out_clip", out_clip, it.clp);
          if (it.fresh && it.clp) exp_evt = 4'(1 << it.ch);
          it.fresh = 1'b0;
          sb[0]    = it;
          if (out_ready) void'(sb.pop_front());
        end
        check("clip_evt", clip_evt, exp_evt);
`ifdef CLIP_RR_STATS_EN
        exp_cnt = '0;
        for (int c = 0; c < NCH; c++) exp_cnt[c*16 +: 16] = 16'(m_cnt[c]);
        check("stat_cnt", stat_cnt, exp_cnt);
        for (int c = 0; c < NCH; c++)
          if (exp_evt[c] && m_cnt[c] < 65535) m_cnt[c] = m_cnt[c] + 1;
`else
        exp_cnt = '0;
`endif
      end
    end
  end

  initial begin : p_stim
    in_rst    = 1'b1;
    set_stb   = 1'b0;
    set_addr  = '0;
    set_data  = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    rprob     = 100;
    gen_mode  = 0;
    for (int c = 0; c < NCH; c++) begin
      src_v[c] = 1'b0; src_d[c] = '0; vprob[c] = 0;
    end
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_chan",  out_chan,  0);
    check("rst_out_clip",  out_clip,  0);
    check("rst_clip_evt",  clip_evt,  0);
    check("rst_in_ready",  in_ready,  0);
    rst = 1'b0;
    #1 in_rst = 1'b0;

    // Boundary samples on every channel.
    set_src(0, 24'hFF8000);
    set_src(1, 24'h007FFF);
    set_src(2, 24'h008000);
    set_src(3, 24'hFF7FFF);
    repeat (8) cycle(1'b0, 8'd0, 32'd0);

    // Continuous traffic, free-running drain.
    for (int c = 0; c < NCH; c++) vprob[c] = 100;
    repeat (24) cycle(1'b0, 8'd0, 32'd0);

    // Back-pressure while full, then release.
    rprob = 0;
    repeat (5) cycle(1'b0, 8'd0, 32'd0);
    rprob = 100;
    repeat (8) cycle(1'b0, 8'd0, 32'd0);

    // Mask down to channels 0 and 2.
    cycle(1'b1, 8'd0, 32'h0000_0500);
    repeat (20) cycle(1'b0, 8'd0, 32'd0);

    // Bypass with a value that would otherwise clip.
    cycle(1'b1, 8'd0, 32'h0000_0F01);
    for (int c = 0; c < NCH; c++) vprob[c] = 0;
    repeat (4) cycle(1'b0, 8'd0, 32'd0);
    set_src(0, 24'h123456);
    repeat (4) cycle(1'b0, 8'd0, 32'd0);
    cycle(1'b1, 8'd0, 32'h0000_0F00);

    // Random traffic, back-pressure and config writes.
    for (int blk = 0; blk < 15; blk++) begin
      for (int c = 0; c < NCH; c++) vprob[c] = $urandom_range(100);
      rprob = $urandom_range(20, 100);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(15) == 0)
          cycle(1'b1, 8'($urandom_range(2)),
                {20'd0, 4'($urandom), 7'd0, 1'($urandom_range(3) == 0)});
        else
          cycle(1'b0, 8'd0, 32'd0);
      end
    end
    cycle(1'b1, 8'd0, 32'h0000_0F00);

`ifdef CLIP_RR_STATS_EN
    for (int c = 0; c < NCH; c++) vprob[c] = 0;
    rprob = 100;
    repeat (4) cycle(1'b0, 8'd0, 32'd0);
    cycle(1'b1, 8'd1, 32'd0);
    vprob[2] = 100;
    gen_mode = 1;
    repeat (70000) cycle(1'b0, 8'd0, 32'd0);
    vprob[2] = 0;
    gen_mode = 0;
    repeat (4) cycle(1'b0, 8'd0, 32'd0);
    check("cnt2_saturated", stat_cnt[2*CNT_W +: CNT_W], 16'hFFFF);
    cycle(1'b1, 8'd1, 32'd0);
    repeat (2) cycle(1'b0, 8'd0, 32'd0);
    check("cnt_cleared", stat_cnt, '0);
`endif

    // Asynchronous reset in the middle of a burst.
    for (int c = 0; c < NCH; c++) vprob[c] = 100;
    rprob = 100;
    repeat (10) cycle(1'b0, 8'd0, 32'd0);
    @(posedge clk);
    #2;
    check("pre_rst_valid", out_valid, 1);
    in_rst   = 1'b1;
    rst      = 1'b1;
    in_valid = '0;
    set_stb  = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready",  in_ready,  0);
    check("mid_rst_out_data",  out_data,  0);
    if (gnt_ch >= 0) src_v[gnt_ch] = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1 in_rst = 1'b0;
    repeat (30) cycle(1'b0, 8'd0, 32'd0);

    for (int c = 0; c < NCH; c++) vprob[c] = 0;
    repeat (6) cycle(1'b0, 8'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
